uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- Byte-stream UART transmitter (8N1) running in the 1 MHz clock domain produced by the UART PLL.
- Holds bytes from the upstream producer (ADC readout path) in a small FIFO and serializes them onto txd.
- Qualifies all activity with the PLL locked output, so no frame is ever emitted on an unlocked clock.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (1 MHz / 104 ≈ 9615 baud); legal range 2..65535.
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W entries.

Ports:
- refclk  input  1  block clock, driven by PLL outclk_0 (1 MHz).
- rst  input  1  synchronous, active-high reset.
- pll_locked  input  1  PLL locked flag; asynchronous to refclk.
- s_data  input  8  byte to transmit.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept; transfer occurs when s_valid & s_ready at a rising edge.
- txd  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- fifo_level  output  ADDR_W+1  number of bytes queued (excludes the byte being shifted).

Behaviour:
- One clock (refclk). Reset is synchronous and active-high (rst).
- Reset values: txd=1, s_ready=0, busy=0, fifo_level=0, FSM=IDLE, lock synchronizer=00.
- Lock qualification:
  - pll_locked passes through a 2-flop synchronizer to produce lock_ok.
  - A rise on pll_locked is reflected in lock_ok on the 2nd edge after the rise.
  - lock_ok=0 acts as a soft reset: FIFO flushed (level 0), FSM forced to IDLE, txd=1, s_ready=0. A frame in progress is aborted, never resumed, and is not counted as sent.
- s_ready = lock_ok & (fifo_level < 2**ADDR_W).
  - When full, no push is accepted even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full; level is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - Baud counter runs 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
  - IDLE: txd=1, busy=0. If the FIFO is non-empty, pop the head into the shift register and go to START on the next cycle.
  - START: txd=0 for one bit time, then go to DATA with bit index 0.
  - DATA: txd = shift[0], LSB first. The register shifts right at each bit end. After bit index 7 completes, go to STOP.
  - STOP: txd=1 for one bit time. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
  - busy=1 in START, DATA and STOP.
- Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge N sets fifo_level=1 after N. The pop occurs at N+1; txd falls low after edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles from txd falling to the end of the stop bit.
- fifo_level wraps nowhere: it saturates by construction, because s_ready blocks pushes when full.
- Pointers are ADDR_W bits and wrap modulo depth.
- rst asserted mid-frame: takes effect on that edge; txd=1 on the next cycle.
- s_data is ignored when s_valid=0 or s_ready=0.

Test Plan (CLKS_PER_BIT=4, ADDR_W=2 unless stated):
- Reset/lock: rst=1 for 3 cycles, pll_locked=0 -> txd=1, s_ready=0, busy=0, fifo_level=0. Raise pll_locked -> s_ready=1 on the 2nd edge after the rise.
- Single byte 0xA5 accepted at edge N:
  - txd low after N+2.
  - Data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop high for 4 cycles.
  - busy high for 40 cycles.
- Back-to-back 0x00 then 0xFF: stop bit of frame 1 is followed immediately by the start bit of frame 2, with no extra idle cycle; 80 cycles of busy total.
- Fill: push 6 bytes with s_valid held high while the first is shifting -> fifo_level reaches 4, s_ready drops to 0, no byte is lost or duplicated. The receiver model decodes all 6 in order.
- Lock loss mid-frame: drop pll_locked during DATA bit 3 of 0x3C with 2 bytes queued:
  - Two edges later: txd=1, busy=0, fifo_level=0, s_ready=0.
  - After re-lock, a new byte 0x81 transmits correctly.
- Default params: CLKS_PER_BIT=104 -> bit period exactly 104 cycles (104 µs at 1 MHz); frame = 1040 cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a small byte FIFO, qualified by a synchronized PLL lock flag.
// txd and busy are registered, so the line trails the FSM state by one cycle.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 2
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              txd,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_level
);

    localparam int          DEPTH     = 1 << ADDR_W;
    localparam int          LW        = ADDR_W + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic              lock_meta;
    logic              lock_ok;
    logic              flush;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    state_t            state, state_d;
    logic [15:0]       baud_cnt, baud_cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [7:0]        shift, shift_d;
    logic              txd_d;
    logic              bit_end;

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_ok   <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_ok   <= lock_meta;
        end
    end

    // Keyed off the value about to enter lock_ok, so the flush lands on the same edge lock_ok drops.
    assign flush      = ~lock_meta;
    assign s_ready    = lock_ok & ~fifo_level[ADDR_W];
    assign push       = s_valid & s_ready;
    assign fifo_empty = (fifo_level == '0);
    assign bit_end    = (baud_cnt == BAUD_LAST);

    // NOTE: storage has no reset; fifo_level alone decides which entries are meaningful.
    always_ff @(posedge refclk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt + 16'd1;
        bit_idx_d  = bit_idx;
        shift_d    = shift;
        pop        = 1'b0;
        txd_d      = 1'b1;
        case (state)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                txd_d = shift[0];
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift[7:1]};
                    bit_idx_d  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge refclk) begin
        if (rst || flush) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            txd      <= txd_d;
            busy     <= (state != IDLE);
        end
    end

endmodule
